cp0_regs: RTL and testbench
===========================

// Module: cp0_regs
// PURPOSE
//  MIPS CP0 register file: the responder for writeback-stage CP0 traffic (exception commit, ERET, MTC0 writes, MFC0/EPC reads).
//  Holds BadVAddr, Count, Compare, Status, Cause and EPC.
//  Generates the interrupt request consumed by the pipeline front end.
// PARAMETERS
//  STATUS_RST  32'h0040_0000  Status reset value (BEV=1, all other bits 0)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  wb_ex        in   1   exception commits this cycle (qualified by WB valid)
//  wb_excode    in   5   ExcCode of the committing exception
//  wb_bd        in   1   excepting instruction is in a delay slot
//  wb_pc        in   32  PC of the excepting instruction
//  wb_badv_we   in   1   exception is address-type; load BadVAddr
//  wb_badvaddr  in   32  faulting address
//  eret         in   1   ERET commits this cycle
//  mtc0_we      in   1   MTC0 write strobe
//  mtc0_addr    in   5   CP0 register number (sel 0 only)
//  mtc0_wdata   in   32  MTC0 data
//  raddr        in   5   read register number
//  rdata        out  32  read data (combinational)
//  ext_int      in   6   hardware interrupt lines, level, active-high
//  epc_out      out  32  current EPC (ERET target)
//  status_out   out  32  current Status
//  cause_out    out  32  current Cause
//  int_req      out  1   interrupt pending and enabled
// BEHAVIOUR
//  Reset: Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare, tick = 0; int_req=0; rdata follows raddr.
//  Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other number reads 0; writes to it are ignored.
//  Writes take effect at the next clk edge.
//  Reads are combinational from the registers; a same-cycle write is not bypassed, so the read returns the old value.
//  Status writable bits: IM[15:8], EXL[1], IE[0]. BEV[22]=1 is read-only. All other bits read 0.
//  Cause writable bits: IP[9:8] only. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are hardware-owned. Unlisted bits read 0.
//  wb_ex: Status.EXL<=1; Cause.ExcCode<=wb_excode.
//   - If EXL was 0: EPC<=wb_bd ? wb_pc-4 : wb_pc, and Cause.BD<=wb_bd.
//   - If EXL was 1: EPC and BD are unchanged.
//   - BadVAddr<=wb_badvaddr when wb_badv_we.
//  eret: Status.EXL<=0.
//  Priority per field: wb_ex > eret > mtc0. An MTC0 in the same cycle as wb_ex/eret is dropped only for fields those events update.
//  IP[7:2] sampled every cycle: IP7<=ext_int[5]|TI; IP[6:2]<=ext_int[4:0].
//  int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). Combinational from registers.
//  epc_out/status_out/cause_out are direct register copies. zero latency.
// CONFIGURATION
//  CP0_TIMER_EN defined:
//   - tick toggles every cycle; Count increments (mod 2^32) on cycles where tick=1, i.e. every 2nd cycle.
//   - MTC0 Count loads Count; tick is unaffected.
//   - TI<=1 on the edge after Count==Compare while tick=1 (i.e. at the increment instant).
//   - MTC0 Compare loads Compare and clears TI; the clear wins over a simultaneous set.
//  CP0_TIMER_EN undefined:
//   - No Count/Compare storage; both read 0 and writes to them are ignored.
//   - TI=0, so IP7=ext_int[5].
// TESTING
//  T1 reset:
//   - reset 1 cycle -> Status=0x0040_0000, Cause=0, EPC=0, int_req=0.
//  T2 exception:
//   - wb_ex=1, excode=0x04, wb_bd=1, pc=0xBFC0_0104, badv_we=1, badvaddr=0x1003 -> next cycle EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1003, Status.EXL=1.
//   - Second wb_ex with pc=0x80 -> EPC unchanged.
//  T3 eret + priority:
//   - eret with EXL=1 -> EXL=0 next cycle.
//   - eret together with MTC0 Status=0x0000_FF03 -> Status=0x0040_FF01 (EXL cleared, IM/IE written).
//  T4 software interrupt:
//   - MTC0 Status=0x0000_0101, then MTC0 Cause=0x0000_0100 -> int_req=1 one cycle after the Cause write.
//   - Setting EXL -> int_req=0.
//  T5 timer (CP0_TIMER_EN):
//   - MTC0 Compare=5, Count=0, Status=0x0000_8001 -> TI=1 and int_req=1 about 10 cycles later.
//   - MTC0 Compare=100 -> TI=0 and int_req=0 next cycle.
//   - Without CP0_TIMER_EN: reading 9 or 11 returns 0.
//  T6 reads:
//   - raddr=10 -> rdata=0.
//   - MTC0 EPC=0x1234 with raddr=14 in the same cycle -> rdata is the old EPC, and 0x1234 the next cycle.

Source files
------------

// File: rtl/cp0_regs.sv
// rtl/cp0_regs.sv - MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC and interrupt request.
// Optional timer (Count/Compare/TI) enabled by defining CP0_TIMER_EN.
module cp0_regs #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic        wb_badv_we,
    input  logic [31:0] wb_badvaddr,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  ext_int,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic        int_req
);

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        ti_d;

    logic wr_status, wr_cause, wr_epc;
    assign wr_status = mtc0_we && (mtc0_addr == 5'd12);
    assign wr_cause  = mtc0_we && (mtc0_addr == 5'd13);
    assign wr_epc    = mtc0_we && (mtc0_addr == 5'd14);

`ifdef CP0_TIMER_EN
    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        wr_count, wr_compare;
    assign wr_count   = mtc0_we && (mtc0_addr == 5'd9);
    assign wr_compare = mtc0_we && (mtc0_addr == 5'd11);

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = cause_q[30];
        if (wr_count)
            count_d = mtc0_wdata;
        if (tick_q && (count_q == compare_q))
            ti_d = 1'b1;
        // A Compare write acknowledges the timer and beats a same-cycle match.
        if (wr_compare) begin
            compare_d = mtc0_wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end
`else
    assign ti_d = 1'b0;
`endif

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        // MTC0 first so eret/wb_ex overwrite only the fields they own.
        if (wr_status)
            status_d = (status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
        if (wr_cause)
            cause_d[9:8] = mtc0_wdata[9:8];
        if (wr_epc)
            epc_d = mtc0_wdata;

        cause_d[30]    = ti_d;
        cause_d[15:10] = {ext_int[5] | ti_d, ext_int[4:0]};

        if (eret)
            status_d[1] = 1'b0;

        if (wb_ex) begin
            status_d[1]  = 1'b1;
            cause_d[6:2] = wb_excode;
            if (!status_q[1]) begin
                epc_d       = wb_bd ? wb_pc - 32'd4 : wb_pc;
                cause_d[31] = wb_bd;
            end
            if (wb_badv_we)
                badvaddr_d = wb_badvaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            5'd8:  rdata = badvaddr_q;
`ifdef CP0_TIMER_EN
            5'd9:  rdata = count_q;
            5'd11: rdata = compare_q;
`endif
            5'd12: rdata = status_q;
            5'd13: rdata = cause_q;
            5'd14: rdata = epc_q;
            default: rdata = 32'd0;
        endcase
    end

    assign epc_out    = epc_q;
    assign status_out = status_q;
    assign cause_out  = cause_q;
    assign int_req    = status_q[0] & ~status_q[1] & |(cause_q[15:8] & status_q[15:8]);

endmodule

// File: tb/tb_cp0_regs.sv
// tb/tb_cp0_regs.sv - self-checking bench for cp0_regs: vector table with post-edge scoreboard plus timer/read sequences.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic        wb_badv_we;
    logic [31:0] wb_badvaddr;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  ext_int;
    logic [31:0] epc_out;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic        int_req;

    always #5 clk = ~clk;

    cp0_regs #(.STATUS_RST(32'h0040_0000)) dut (
        .clk(clk), .reset(reset),
        .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
        .wb_badv_we(wb_badv_we), .wb_badvaddr(wb_badvaddr), .eret(eret),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .raddr(raddr), .rdata(rdata), .ext_int(ext_int),
        .epc_out(epc_out), .status_out(status_out), .cause_out(cause_out),
        .int_req(int_req)
    );

    typedef struct {
        logic        ex;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] pc;
        logic        bwe;
        logic [31:0] bva;
        logic        er;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [5:0]  ei;
        logic [31:0] erd;
        logic [31:0] es;
        logic [31:0] ec;
        logic [31:0] ee;
        logic        eint;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] es;
        logic [31:0] ec;
        logic [31:0] ee;
        logic        eint;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];
    int    passed = 0;
    int    total  = 0;

    function automatic vec_t mk(logic ex, logic [4:0] code, logic bd, logic [31:0] pc,
                                logic bwe, logic [31:0] bva, logic er, logic we,
                                logic [4:0] addr, logic [31:0] wd, logic [4:0] ra,
                                logic [5:0] ei, logic [31:0] erd, logic [31:0] es,
                                logic [31:0] ec, logic [31:0] ee, logic eint);
        vec_t v;
        v.ex = ex; v.code = code; v.bd = bd; v.pc = pc; v.bwe = bwe; v.bva = bva;
        v.er = er; v.we = we; v.addr = addr; v.wd = wd; v.ra = ra; v.ei = ei;
        v.erd = erd; v.es = es; v.ec = ec; v.ee = ee; v.eint = eint;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle();
        wb_ex = 0; wb_excode = 0; wb_bd = 0; wb_pc = 0; wb_badv_we = 0; wb_badvaddr = 0;
        eret = 0; mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0;
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d;
        @(negedge clk);
        mtc0_we = 0;
    endtask

    initial begin
        post_t p;
        idle();
        raddr = 0; ext_int = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        check("rst_status", status_out, 32'h0040_0000);
        check("rst_cause", cause_out, 32'h0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_int", {31'd0, int_req}, 32'h0);

        //          ex code  bd pc            bwe bva   er we addr wd            ra  ei     rd            status        cause         epc           int
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 32'h0,        0));
        vecs.push_back(mk(1, 5'h04, 1, 32'hBFC0_0104, 1, 32'h1003, 0, 0, 5'd0,  32'h0,        5'd8,  6'h00, 32'h0,         32'h0040_0002, 32'h8000_0010, 32'hBFC0_0100, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 0, 5'd0,  32'h0,        5'd8,  6'h00, 32'h0000_1003, 32'h0040_0002, 32'h8000_0010, 32'hBFC0_0100, 0));
        vecs.push_back(mk(1, 5'h05, 0, 32'h80,       0, 32'h0,    0, 0, 5'd0,  32'h0,        5'd14, 6'h00, 32'hBFC0_0100, 32'h0040_0002, 32'h8000_0014, 32'hBFC0_0100, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    1, 0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h0040_0002, 32'h0040_0000, 32'h8000_0014, 32'hBFC0_0100, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    1, 1, 5'd12, 32'h0000_FF03, 5'd12, 6'h00, 32'h0040_0000, 32'h0040_FF01, 32'h8000_0014, 32'hBFC0_0100, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd12, 32'h0000_0101, 5'd13, 6'h00, 32'h8000_0014, 32'h0040_0101, 32'h8000_0014, 32'hBFC0_0100, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd13, 32'hFFFF_FD00, 5'd13, 6'h00, 32'h8000_0014, 32'h0040_0101, 32'h8000_0114, 32'hBFC0_0100, 1));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd12, 32'h0000_0103, 5'd12, 6'h00, 32'h0040_0101, 32'h0040_0103, 32'h8000_0114, 32'hBFC0_0100, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd12, 32'h0000_0101, 5'd10, 6'h00, 32'h0,         32'h0040_0101, 32'h8000_0114, 32'hBFC0_0100, 1));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd14, 32'h0000_1234, 5'd14, 6'h00, 32'hBFC0_0100, 32'h0040_0101, 32'h8000_0114, 32'h0000_1234, 1));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 0, 5'd0,  32'h0,        5'd14, 6'h00, 32'h0000_1234, 32'h0040_0101, 32'h8000_0114, 32'h0000_1234, 1));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd13, 32'h0,        5'd13, 6'h01, 32'h8000_0114, 32'h0040_0101, 32'h8000_0414, 32'h0000_1234, 0));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 1, 5'd12, 32'h0000_0401, 5'd13, 6'h01, 32'h8000_0414, 32'h0040_0401, 32'h8000_0414, 32'h0000_1234, 1));
        vecs.push_back(mk(0, 5'h00, 0, 32'h0,        0, 32'h0,    0, 0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h0040_0401, 32'h0040_0401, 32'h8000_0014, 32'h0000_1234, 0));
        vecs.push_back(mk(1, 5'h00, 0, 32'h200,      0, 32'h0,    1, 1, 5'd12, 32'h0,        5'd14, 6'h00, 32'h0000_1234, 32'h0040_0002, 32'h0000_0000, 32'h0000_0200, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wb_ex = vecs[i].ex; wb_excode = vecs[i].code; wb_bd = vecs[i].bd; wb_pc = vecs[i].pc;
            wb_badv_we = vecs[i].bwe; wb_badvaddr = vecs[i].bva; eret = vecs[i].er;
            mtc0_we = vecs[i].we; mtc0_addr = vecs[i].addr; mtc0_wdata = vecs[i].wd;
            raddr = vecs[i].ra; ext_int = vecs[i].ei;
            #1;
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].erd);
            p.idx = i; p.es = vecs[i].es; p.ec = vecs[i].ec; p.ee = vecs[i].ee; p.eint = vecs[i].eint;
            sb.push_back(p);
            @(posedge clk);
            #1;
            p = sb.pop_front();
            check($sformatf("v%0d_status", p.idx), status_out, p.es);
            check($sformatf("v%0d_cause", p.idx), cause_out, p.ec);
            check($sformatf("v%0d_epc", p.idx), epc_out, p.ee);
            check($sformatf("v%0d_int", p.idx), {31'd0, int_req}, {31'd0, p.eint});
        end

        @(negedge clk);
        idle();
        ext_int = 0;

`ifdef CP0_TIMER_EN
        begin
            int waited;
            do_mtc0(5'd11, 32'd5);
            do_mtc0(5'd9, 32'd0);
            raddr = 5'd9;
            #1;
            check("count_load", rdata, 32'd0);
            do_mtc0(5'd12, 32'h0000_8001);
            waited = 0;
            while (!cause_out[30] && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            #1;
            check("ti_set", {31'd0, cause_out[30]}, 32'd1);
            check("ti_ip7", {31'd0, cause_out[15]}, 32'd1);
            check("ti_int", {31'd0, int_req}, 32'd1);
            check("ti_count", rdata, 32'd6);
            @(negedge clk);
            mtc0_we = 1; mtc0_addr = 5'd11; mtc0_wdata = 32'd100;
            @(posedge clk);
            #1;
            mtc0_we = 0;
            check("ti_clear", {31'd0, cause_out[30]}, 32'd0);
            check("ti_clear_int", {31'd0, int_req}, 32'd0);
            raddr = 5'd11;
            #1;
            check("compare_rd", rdata, 32'd100);
        end
`else
        do_mtc0(5'd9, 32'h55);
        do_mtc0(5'd11, 32'h66);
        raddr = 5'd9;
        #1;
        check("count_rd0", rdata, 32'd0);
        raddr = 5'd11;
        #1;
        check("compare_rd0", rdata, 32'd0);
        check("no_ti", {31'd0, cause_out[30]}, 32'd0);
        @(negedge clk);
        ext_int = 6'h20;
        do_mtc0(5'd12, 32'h0000_8001);
        #1;
        check("ip7_ext", {31'd0, cause_out[15]}, 32'd1);
        check("ip7_int", {31'd0, int_req}, 32'd1);
        ext_int = 0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
